memory_responder: RTL and testbench

//  Memory-side responder for the core's read/write memory port: services one word read
//  and/or one masked word write per request from a word-addressed internal array.

---
 rtl/memory_responder.sv | 168 ++++++++++++++++
 tb/tb_memory_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Handshaked word memory responder: one masked write and/or one read per accepted request,
// optional wait states. Define MEMORY_RANGE_CHECK_EN to flag/suppress out-of-range accesses.
module memory_responder #(
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
   parameter int unsigned WAIT_STATES  = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read_request,
   input  logic [31:0] read_memory_address,
   input  logic        write_request,
   input  logic [31:0] write_memory_address,
   input  logic [31:0] write_memory_data,
   input  logic [31:0] write_memory_mask,
   output logic        ready,
   output logic        response_valid,
   output logic [31:0] read_memory_data,
   output logic        access_error
);
   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          ready_q, ready_d;
   logic          rv_q, rv_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          rd_q, rd_d, wr_q, wr_d;
   logic          rd_oob_q, rd_oob_d, wr_oob_q, wr_oob_d;
   logic [AW-1:0] rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
   logic [31:0]   wdata_q, wdata_d, wmask_q, wmask_d;

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic          accept_s, mem_we_s, rd_oob_s, wr_oob_s;
   logic [31:0]   rd_diff_s, wr_diff_s, merged_s, rd_word_s;
   logic          unused_s;

   assign accept_s  = ready_q && (read_request || write_request);
   assign rd_diff_s = read_memory_address - BASE_ADDRESS;
   assign wr_diff_s = write_memory_address - BASE_ADDRESS;

`ifdef MEMORY_RANGE_CHECK_EN
   // Word index beyond the array (a wrap below BASE_ADDRESS lands here too) is out of range.
   assign rd_oob_s = ({2'b00, rd_diff_s[31:2]} >= 32'(DEPTH_WORDS));
   assign wr_oob_s = ({2'b00, wr_diff_s[31:2]} >= 32'(DEPTH_WORDS));
   assign unused_s = ^{rd_diff_s[1:0], wr_diff_s[1:0]};
`else
   assign rd_oob_s = 1'b0;
   assign wr_oob_s = 1'b0;
   assign unused_s = ^{rd_diff_s[31:AW+2], rd_diff_s[1:0], wr_diff_s[31:AW+2], wr_diff_s[1:0]};
`endif

   assign mem_we_s  = (state_q == ST_RESP) && wr_q && !wr_oob_q;
   assign merged_s  = (mem_q[wr_idx_q] & ~wmask_q) | (wdata_q & wmask_q);
   assign rd_word_s = (mem_we_s && (wr_idx_q == rd_idx_q)) ? merged_s : mem_q[rd_idx_q];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         ready_q  <= 1'b1;
         rv_q     <= 1'b0;
         rdata_q  <= 32'h0000_0000;
         err_q    <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         rd_oob_q <= 1'b0;
         wr_oob_q <= 1'b0;
         rd_idx_q <= '0;
         wr_idx_q <= '0;
         wdata_q  <= 32'h0000_0000;
         wmask_q  <= 32'h0000_0000;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         rv_q     <= rv_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         rd_oob_q <= rd_oob_d;
         wr_oob_q <= wr_oob_d;
         rd_idx_q <= rd_idx_d;
         wr_idx_q <= wr_idx_d;
         wdata_q  <= wdata_d;
         wmask_q  <= wmask_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               if (WAIT_STATES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ready_d  = (state_d == ST_IDLE);
      rv_d     = (state_q == ST_RESP);
      err_d    = 1'b0;
      rdata_d  = rdata_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      rd_oob_d = rd_oob_q;
      wr_oob_d = wr_oob_q;
      rd_idx_d = rd_idx_q;
      wr_idx_d = wr_idx_q;
      wdata_d  = wdata_q;
      wmask_d  = wmask_q;
      if (state_q == ST_RESP) begin
         err_d = (rd_q && rd_oob_q) || (wr_q && wr_oob_q);
         if (rd_q) begin
            rdata_d = rd_oob_q ? 32'h0000_0000 : rd_word_s;
         end else begin
            rdata_d = rdata_q;
         end
      end else if (state_q == ST_IDLE && accept_s) begin
         rd_d     = read_request;
         wr_d     = write_request;
         rd_oob_d = rd_oob_s;
         wr_oob_d = wr_oob_s;
         rd_idx_d = rd_diff_s[AW+1:2];
         wr_idx_d = wr_diff_s[AW+1:2];
         wdata_d  = write_memory_data;
         wmask_d  = write_memory_mask;
      end else begin
         err_d = 1'b0;
      end
   end

   // Array is deliberately outside the reset domain; a reset before the RESPOND edge blocks the commit.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[wr_idx_q] <= merged_s;
      end
   end

   assign ready            = ready_q;
   assign response_valid   = rv_q;
   assign read_memory_data = rdata_q;
   assign access_error     = err_q;
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: a zero-wait instance (1024 words) and a three-wait instance
// (16 words), directed scenarios then random traffic checked against an array model.
module tb_memory_responder;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  rd_req = 2'b00;
   logic [1:0]  wr_req = 2'b00;
   logic [31:0] ra [2];
   logic [31:0] wa [2];
   logic [31:0] wd [2];
   logic [31:0] wm [2];
   logic [1:0]  rdy, rv, aerr;
   logic [31:0] rdata [2];

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] mdl [2][1024];
   logic [31:0] exp_rd [2];

   always #5 clk = ~clk;

   memory_responder #(.DEPTH_WORDS(1024), .BASE_ADDRESS(32'h0000_0000), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .reset(reset),
      .read_request(rd_req[0]), .read_memory_address(ra[0]),
      .write_request(wr_req[0]), .write_memory_address(wa[0]),
      .write_memory_data(wd[0]), .write_memory_mask(wm[0]),
      .ready(rdy[0]), .response_valid(rv[0]), .read_memory_data(rdata[0]), .access_error(aerr[0]));

   memory_responder #(.DEPTH_WORDS(16), .BASE_ADDRESS(32'h0000_0000), .WAIT_STATES(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .read_request(rd_req[1]), .read_memory_address(ra[1]),
      .write_request(wr_req[1]), .write_memory_address(wa[1]),
      .write_memory_data(wd[1]), .write_memory_mask(wm[1]),
      .ready(rdy[1]), .response_valid(rv[1]), .read_memory_data(rdata[1]), .access_error(aerr[1]));

   function automatic int unsigned ws_of(input int sel);
      return (sel == 1) ? 3 : 0;
   endfunction

   function automatic int unsigned depth_of(input int sel);
      return (sel == 1) ? 16 : 1024;
   endfunction

   // Byte address -> word index and out-of-range flag, straight from the addressing rules.
   task automatic map_addr(input int sel, input logic [31:0] addr,
                           output int unsigned idx, output bit oob);
      logic [31:0] word;
      word = (addr - 32'h0000_0000) >> 2;
`ifdef MEMORY_RANGE_CHECK_EN
      oob = (word >= depth_of(sel));
      idx = oob ? 0 : int'(word);
`else
      oob = 1'b0;
      idx = int'(word % depth_of(sel));
`endif
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input int sel, input bit rd, input bit wr,
                         input logic [31:0] raddr, input logic [31:0] waddr,
                         input logic [31:0] wdata, input logic [31:0] wmask, input bit junk);
      int unsigned ri, wi;
      bit roob, woob, exp_err, got;
      int n;
      chk("ready_idle", 32'(rdy[sel]), 32'd1);
      rd_req[sel] = rd; wr_req[sel] = wr;
      ra[sel] = raddr; wa[sel] = waddr; wd[sel] = wdata; wm[sel] = wmask;
      @(posedge clk); #1;
      rd_req[sel] = 1'b0; wr_req[sel] = 1'b0;
      map_addr(sel, raddr, ri, roob);
      map_addr(sel, waddr, wi, woob);
      if (wr && !woob) mdl[sel][wi] = (mdl[sel][wi] & ~wmask) | (wdata & wmask);
      if (rd) exp_rd[sel] = roob ? 32'h0000_0000 : mdl[sel][ri];
      exp_err = (rd && roob) || (wr && woob);
      got = 1'b0;
      n = 0;
      while (!got && n < 40) begin
         n++;
         if (junk) begin
            wr_req[sel] = 1'b1; wa[sel] = waddr; wd[sel] = ~wdata; wm[sel] = 32'hFFFF_FFFF;
         end
         @(posedge clk); #1;
         if (rv[sel]) got = 1'b1;
         else chk("ready_busy", 32'(rdy[sel]), 32'd0);
      end
      wr_req[sel] = 1'b0;
      if (!got) begin
         chk("resp_timeout", 32'd0, 32'd1);
      end else begin
         chk("latency", 32'(n), 32'(ws_of(sel) + 1));
         chk("rdata", rdata[sel], exp_rd[sel]);
         chk("access_error", 32'(aerr[sel]), 32'(exp_err));
         chk("ready_after", 32'(rdy[sel]), 32'd1);
      end
   endtask

   function automatic logic [31:0] rand_addr(input int sel);
      int unsigned w;
      if (sel == 1) w = $urandom_range(0, 31);
      else w = $urandom_range(0, 15) + (($urandom_range(0, 3) == 0) ? 1024 : 0);
      return 32'(w * 4 + $urandom_range(0, 3));
   endfunction

   initial begin
      logic [31:0] mask, w0;
      for (int s = 0; s < 2; s++) begin
         ra[s] = 32'h0; wa[s] = 32'h0; wd[s] = 32'h0; wm[s] = 32'h0; exp_rd[s] = 32'h0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(rdy), 32'd3);
      chk("rst_rv", 32'(rv), 32'd0);
      chk("rst_err", 32'(aerr), 32'd0);
      chk("rst_rdata0", rdata[0], 32'h0);
      chk("rst_rdata1", rdata[1], 32'h0);
      reset = 1'b1;
      @(posedge clk); #1;

      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 16; i++)
            do_req(s, 1'b0, 1'b1, 32'h0, 32'(i * 4), $urandom, 32'hFFFF_FFFF, 1'b0);

      // Zero-wait full write then read back
      do_req(0, 1'b0, 1'b1, 32'h0, 32'h8, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);
      do_req(0, 1'b1, 1'b0, 32'h8, 32'h0, 32'h0, 32'h0, 1'b0);
      chk("t2_value", rdata[0], 32'hDEAD_BEEF);

      // Partial byte-lane write
      do_req(0, 1'b0, 1'b1, 32'h0, 32'h4, 32'h1122_3344, 32'hFFFF_FFFF, 1'b0);
      do_req(0, 1'b0, 1'b1, 32'h0, 32'h4, 32'h0000_AA00, 32'h0000_FF00, 1'b0);
      do_req(0, 1'b1, 1'b0, 32'h4, 32'h0, 32'h0, 32'h0, 1'b0);
      chk("t3_merge", rdata[0], 32'h1122_AA44);

      // Write-only keeps the last read data
      do_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      w0 = rdata[0];
      do_req(0, 1'b0, 1'b1, 32'h0, 32'h4, 32'h9999_0000, 32'hFFFF_FFFF, 1'b0);
      chk("t6_hold", rdata[0], w0);

      // Address one past the array
      do_req(0, 1'b0, 1'b1, 32'h0, 32'h1000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0);
      do_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef MEMORY_RANGE_CHECK_EN
      chk("t5_word0", rdata[0], w0);
`else
      chk("t5_word0", rdata[0], 32'h0000_0007);
`endif

      // Wait-stated read+write of the same word, with a request held while busy
      do_req(1, 1'b1, 1'b1, 32'hC, 32'hC, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
      chk("t4_value", rdata[1], 32'h0000_0005);
      do_req(1, 1'b1, 1'b0, 32'hC, 32'h0, 32'h0, 32'h0, 1'b0);
      chk("t4_ignored", rdata[1], 32'h0000_0005);

      // Reset during WAIT with a pending write
      wr_req[1] = 1'b1; wa[1] = 32'h10; wd[1] = 32'hCAFE_F00D; wm[1] = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      wr_req[1] = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("t1_ready", 32'(rdy[1]), 32'd1);
      chk("t1_rv", 32'(rv[1]), 32'd0);
      chk("t1_rdata", rdata[1], 32'h0);
      exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
      @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("t1_no_resp", 32'(rv[1]), 32'd0);
      end
      do_req(1, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0);

      // Random traffic against the array model
      for (int it = 0; it < 120; it++) begin
         int sel;
         bit rd, wr;
         sel = int'($urandom_range(0, 1));
         rd = $urandom_range(0, 1) == 1;
         wr = !rd || ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 3))
            0:       mask = 32'h0000_0000;
            1:       mask = 32'hFFFF_FFFF;
            default: mask = $urandom;
         endcase
         do_req(sel, rd, wr, rand_addr(sel), rand_addr(sel), $urandom, mask,
                (sel == 1) && ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
            chk("idle_rv", 32'(rv), 32'd0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
